// File: rtl/running_mean.sv
// Moving-average filter over the last 2**LOG2_N unsigned samples.
// The output is the truncated mean of a zero-filled shift-register window.
module running_mean #(
    parameter int DATA_W = 4,
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] mean
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_W + LOG2_N;

    // x[0] is the newest sample, x[N-1] the oldest.
    logic [DATA_W-1:0] x [N];
    logic [SUM_W-1:0]  partial [N+1];
    logic [SUM_W-1:0]  m_tmp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x[0] <= '0;
        end else begin
            x[0] <= in;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    x[gi] <= '0;
                end else begin
                    x[gi] <= x[gi-1];
                end
            end
        end

        // Sum is wide enough that N full-scale samples cannot overflow.
        assign partial[0] = '0;
        for (gi = 0; gi < N; gi++) begin : g_sum
            assign partial[gi+1] = partial[gi] + {{LOG2_N{1'b0}}, x[gi]};
        end
    endgenerate

    assign m_tmp = partial[N];
    assign mean  = DATA_W'(m_tmp >> LOG2_N);

endmodule

// File: tb/tb_running_mean.sv
// Directed and random-soak checks for the running_mean filter (defaults: 4-bit data, window 4).
module tb_running_mean;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] mean;

    int pass_cnt = 0;
    int total_cnt = 0;
    int model [4];

    running_mean #(.DATA_W(4), .LOG2_N(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .mean (mean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sample, let it be captured, sample outputs 1 time unit later.
    task automatic step(input int v);
        din = 4'(v);
        @(posedge clk);
        #1;
        $display("in=%0d m_tmp=%0d mean=%0d", v, dut.m_tmp, mean);
    endtask

    // Pulse reset away from any clock edge.
    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int wm [5];
        int wt [5];
        int v;
        int s;
        wm = '{2, 4, 6, 8, 8};
        wt = '{8, 16, 24, 32, 32};

        // Reset held across edges with a nonzero input.
        rst = 1'b0;
        din = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("reset_x%0d", k), dut.x[k], 0);
        check("reset_m_tmp", dut.m_tmp, 0);
        check("reset_mean", mean, 0);
        rst = 1'b1;

        // Warm-up with a constant input.
        for (int i = 0; i < 5; i++) begin
            step(8);
            check($sformatf("warm_mean_%0d", i), mean, wm[i]);
            check($sformatf("warm_m_tmp_%0d", i), dut.m_tmp, wt[i]);
        end

        // Asynchronous reset between edges clears the output.
        rst = 1'b0;
        #2;
        check("async_reset_mean", mean, 0);
        check("async_reset_m_tmp", dut.m_tmp, 0);
        rst = 1'b1;

        // Truncation.
        step(1); step(2); step(3); step(4);
        check("trunc_m_tmp_a", dut.m_tmp, 10);
        check("trunc_mean_a", mean, 2);
        step(5);
        check("trunc_m_tmp_b", dut.m_tmp, 14);
        check("trunc_mean_b", mean, 3);

        // Full scale then drain.
        repeat (4) step(15);
        check("full_m_tmp", dut.m_tmp, 60);
        check("full_mean", mean, 15);
        step(0); check("drain_mean_0", mean, 11);
        step(0); check("drain_mean_1", mean, 7);
        step(0); check("drain_mean_2", mean, 3);
        step(0); check("drain_mean_3", mean, 0);

        // Mid-stream reset discards all history.
        repeat (4) step(12);
        check("mid_fill_mean", mean, 12);
        rst = 1'b0;
        #2;
        check("mid_reset_mean", mean, 0);
        rst = 1'b1;
        step(4);
        check("mid_after_mean", mean, 1);
        check("mid_after_x0", dut.x[0], 4);
        for (int k = 1; k < 4; k++) check($sformatf("mid_after_x%0d", k), dut.x[k], 0);

        // Random soak against a zero-filled window model.
        pulse_reset();
        for (int k = 0; k < 4; k++) model[k] = 0;
        for (int i = 0; i < 100; i++) begin
            v = int'($urandom_range(0, 15));
            for (int k = 3; k > 0; k--) model[k] = model[k-1];
            model[0] = v;
            s = model[0] + model[1] + model[2] + model[3];
            step(v);
            check($sformatf("soak_mean_%0d", i), mean, s / 4);
            for (int k = 0; k < 4; k++) check($sformatf("soak_x%0d_%0d", k, i), dut.x[k], model[k]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
